spi_xfer_sched: RTL and testbench
=================================

# spi_xfer_sched

Wishbone bus-master scheduler that shares one `spi_top` SPI master core among `NREQ` client requesters. It grants clients round-robin and programs the core's divider, slave-select, TX0 and CTRL registers for each granted client. It then polls CTRL until GO clears, reads RX0, and returns the received word to the client with a one-cycle done pulse. It connects directly to the core's Wishbone slave port and is the only master on that port.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 1..8; requester k owns slave-select bit k.
- `DIVIDER`, 16'd4: value written to DIVIDE (0x14) for every transfer.
- `CTRL_FLAGS`, 5'b00000: {ass, ie, lsb, tx_negedge, rx_negedge} placed at CTRL bits [13:9]; ie must be 0.
- `POLL_MAX`, 1024: maximum CTRL reads before timeout.

Ports:
- Clock and reset: `wb_clk_in` in 1: clock. `wb_rst_in` in 1: reset, asynchronous, active-high.
- `req_i` in NREQ: per-client request, held high until that client's done pulse.
- `req_dat_i` in 32*NREQ: TX word, slice k = [32k+31:32k], stable while request is high.
- `req_len_i` in 7*NREQ: char_len per client, 0 = 128 bits, as encoded by the core.
- `done_o` out NREQ: one-cycle pulse to the granted client.
- `rx_dat_o` out 32: RX0 word, valid while `done_o` is high.
- `err_o` out 1: high with `done_o` when the poll timed out.
- `busy_o` out 1: high whenever FSM is not IDLE.
- `m_adr_o` out 5, `m_dat_o` out 32, `m_sel_o` out 4, `m_we_o` out 1, `m_cyc_o` out 1, `m_stb_o` out 1: Wishbone master to core.
- `m_dat_i` in 32, `m_ack_i` in 1: core read data and ack.

## Operation
- FSM states: IDLE, WR_DIV, WR_SS, WR_TX, WR_CTRL, POLL, RD_RX, DONE, with a GAP substate between bus accesses.
- IDLE: if any `req_i` is high, grant the first requesting index at or after `last+1` (mod NREQ). Latch the grant index, TX word and length, then go to WR_DIV. `last` updates to the granted index.
- Bus access: drive `cyc`/`stb`=1 and `sel`=4'hF with adr/we/dat from registered outputs. Hold until `m_ack_i`=1 is sampled. At that edge drop `cyc`/`stb`, and capture `m_dat_i` on reads. Then spend one GAP cycle with `cyc`/`stb`=0 before the next access.
- WR_DIV: adr 0x14, dat = DIVIDER.
- WR_SS: adr 0x18, dat = 1<<grant.
- WR_TX: adr 0x00, dat = TX word.
- WR_CTRL: adr 0x10, dat = {18'b0, CTRL_FLAGS, 1'b1 (GO, bit 8), 1'b0, len[6:0]}.
- POLL: read adr 0x10.
  - Captured bit 8 = 0: go to RD_RX.
  - Otherwise increment the poll counter. If the counter reaches POLL_MAX, go to DONE with err set; else re-poll after GAP.
- RD_RX: read adr 0x00 and capture into `rx_dat_o`.
- DONE: pulse `done_o[grant]` for one cycle and hold `err_o` for that cycle. Clear the poll counter and return to IDLE. A new arbitration can occur on the next cycle.
- `req_i` is sampled only in IDLE. A drop mid-transfer is ignored and the transfer completes.
- On timeout, `rx_dat_o` holds 0 and the core's GO may still be set. Subsequent core writes are blocked by the core while tip is high; this is a system error reported via `err_o`.

## Timing
- Reset values: all master outputs 0; `done_o`=0, `rx_dat_o`=0, `err_o`=0, `busy_o`=0; FSM IDLE; `last`=NREQ-1, so requester 0 wins first.
- Reset asserted mid-access drops `cyc`/`stb` immediately (asynchronous).
- The core acks one cycle after `stb`, so each access takes 2 cycles plus 1 GAP cycle, i.e. 3 cycles per access.
- Grant edge to first `stb`: 1 cycle.
- Best-case latency from request sampled in IDLE to `done_o`: 1 + 4×3 writes + N_poll×3 + 3 (RX) + 1.
- `busy_o` goes high the cycle after grant and low in the cycle after DONE.
- Simultaneous requests are served strictly round-robin. With all NREQ requesting continuously, each client is granted once per NREQ transfers.
- Poll counter is 11 bits wide, saturating at POLL_MAX.

## Test plan
- Single request, client 0, TX=0xA5, len=8, core in loopback (mosi→miso): writes hit 0x14=4, 0x18=1, 0x00=0xA5, 0x10=0x108. `done_o[0]` pulses once, `rx_dat_o`=0x000000A5, `err_o`=0.
- Both clients request together from reset: client 0 is served first, then client 1 with SS=0x2. The next pair again starts with client 0.
- Client 1 requests continuously while client 0 requests once: grants alternate 1,0,1,1… and client 0 waits at most one transfer.
- Force `miso` stuck and len=0 (128 bits) with DIVIDER large and POLL_MAX=4: exactly 4 CTRL reads occur, then `done_o` with `err_o`=1 and `rx_dat_o`=0.
- Assert `wb_rst_in` during POLL: `m_cyc_o`/`m_stb_o` go 0 immediately and all outputs return to reset values. After release the pending request restarts from WR_DIV.
- Bus protocol check throughout: `stb` never high without `cyc`, at least one idle cycle between accesses, and exactly one ack per access.

Source files
------------

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin Wishbone master that time-shares one SPI master
// core among NREQ clients. For each grant it programs DIVIDE, SS, TX0 and CTRL,
// polls CTRL until GO clears (bounded), reads RX0 and pulses done to the client.
module spi_xfer_sched #(
  parameter int          NREQ       = 2,
  parameter logic [15:0] DIVIDER    = 16'd4,
  parameter logic [4:0]  CTRL_FLAGS = 5'b00000,
  parameter int          POLL_MAX   = 1024
) (
  input  logic                 wb_clk_in,
  input  logic                 wb_rst_in,
  input  logic [NREQ-1:0]      req_i,
  input  logic [32*NREQ-1:0]   req_dat_i,
  input  logic [7*NREQ-1:0]    req_len_i,
  output logic [NREQ-1:0]      done_o,
  output logic [31:0]          rx_dat_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic [4:0]           m_adr_o,
  output logic [31:0]          m_dat_o,
  output logic [3:0]           m_sel_o,
  output logic                 m_we_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  input  logic [31:0]          m_dat_i,
  input  logic                 m_ack_i
);

  localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0] POLL_LIM = 11'(POLL_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_POLL, S_RD_RX, S_DONE, S_GAP
  } state_t;

  state_t          state_q, nxt_q;
  logic [IW-1:0]   grant_q, last_q;
  logic [31:0]     tx_q;
  logic [6:0]      len_q;
  logic [10:0]     poll_cnt_q;
  logic            tmo_q;
  logic [NREQ-1:0] done_q;
  logic [31:0]     rx_dat_q;
  logic            err_q, busy_q;
  logic [4:0]      adr_q;
  logic [31:0]     dat_q;
  logic [3:0]      sel_q;
  logic            we_q, cyc_q, stb_q;

  logic [IW-1:0]   grant_d;
  logic            any_req_d;
  logic [31:0]     tx_sel_d;
  logic [6:0]      len_sel_d;
  int              best_d, dist_d;
  logic [NREQ-1:0] grant_oh;
  logic [10:0]     poll_inc_d;

  // Round-robin pick: smallest positive distance from the last grant wins.
  always_comb begin
    grant_d   = last_q;
    any_req_d = 1'b0;
    tx_sel_d  = '0;
    len_sel_d = '0;
    best_d    = NREQ + 1;
    dist_d    = 0;
    for (int k = 0; k < NREQ; k++) begin
      dist_d = (k > int'(last_q)) ? (k - int'(last_q)) : (k + NREQ - int'(last_q));
      if (req_i[k] && (dist_d < best_d)) begin
        best_d    = dist_d;
        grant_d   = IW'(k);
        tx_sel_d  = req_dat_i[32*k +: 32];
        len_sel_d = req_len_i[7*k +: 7];
        any_req_d = 1'b1;
      end
    end
  end

  // One-hot of the current grant, used for SS and the done pulse.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
    assign grant_oh[gi] = (grant_q == IW'(gi));
  end

  // Saturating poll counter increment.
  assign poll_inc_d = (poll_cnt_q == POLL_LIM) ? poll_cnt_q : poll_cnt_q + 11'd1;

  // Main scheduler FSM; every output is a register updated here.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      state_q    <= S_IDLE;
      nxt_q      <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      tx_q       <= '0;
      len_q      <= '0;
      poll_cnt_q <= '0;
      tmo_q      <= 1'b0;
      done_q     <= '0;
      rx_dat_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            grant_q    <= grant_d;
            last_q     <= grant_d;
            tx_q       <= tx_sel_d;
            len_q      <= len_sel_d;
            rx_dat_q   <= '0;
            poll_cnt_q <= '0;
            tmo_q      <= 1'b0;
            busy_q     <= 1'b1;
            nxt_q      <= S_WR_DIV;
            state_q    <= S_GAP;
          end
        end
        // Idle bus cycle; launches the next access (or the done pulse).
        S_GAP: begin
          state_q <= nxt_q;
          if (nxt_q == S_DONE) begin
            done_q <= grant_oh;
            err_q  <= tmo_q;
          end else begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            sel_q <= 4'hF;
            case (nxt_q)
              S_WR_DIV:  begin adr_q <= 5'h14; we_q <= 1'b1; dat_q <= {16'h0, DIVIDER}; end
              S_WR_SS:   begin adr_q <= 5'h18; we_q <= 1'b1; dat_q <= 32'(grant_oh); end
              S_WR_TX:   begin adr_q <= 5'h00; we_q <= 1'b1; dat_q <= tx_q; end
              S_WR_CTRL: begin adr_q <= 5'h10; we_q <= 1'b1; dat_q <= {18'b0, CTRL_FLAGS, 1'b1, 1'b0, len_q}; end
              S_POLL:    begin adr_q <= 5'h10; we_q <= 1'b0; dat_q <= '0; end
              default:   begin adr_q <= 5'h00; we_q <= 1'b0; dat_q <= '0; end
            endcase
          end
        end
        S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL, S_POLL, S_RD_RX: begin
          if (m_ack_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            state_q <= S_GAP;
            case (state_q)
              S_WR_DIV:  nxt_q <= S_WR_SS;
              S_WR_SS:   nxt_q <= S_WR_TX;
              S_WR_TX:   nxt_q <= S_WR_CTRL;
              S_WR_CTRL: nxt_q <= S_POLL;
              S_POLL: begin
                if (!m_dat_i[8]) begin
                  nxt_q <= S_RD_RX;
                end else begin
                  poll_cnt_q <= poll_inc_d;
                  if (poll_inc_d == POLL_LIM) begin
                    tmo_q <= 1'b1;
                    nxt_q <= S_DONE;
                  end else begin
                    nxt_q <= S_POLL;
                  end
                end
              end
              default: begin
                rx_dat_q <= m_dat_i;
                nxt_q    <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          busy_q     <= 1'b0;
          poll_cnt_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done_o   = done_q;
  assign rx_dat_o = rx_dat_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;
  assign m_adr_o  = adr_q;
  assign m_dat_o  = dat_q;
  assign m_sel_o  = sel_q;
  assign m_we_o   = we_q;
  assign m_cyc_o  = cyc_q;
  assign m_stb_o  = stb_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched with a behavioural SPI core register model
// (loopback data path, GO self-clears a few cycles after a CTRL write).
module tb_spi_xfer_sched;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst_in = 1'b1;
  logic [1:0]  req_i     = '0;
  logic [63:0] req_dat_i = '0;
  logic [13:0] req_len_i = '0;
  logic [1:0]  done_o;
  logic [31:0] rx_dat_o;
  logic        err_o, busy_o;
  logic [4:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 wb_clk_in = ~wb_clk_in;

  spi_xfer_sched #(.NREQ(2), .DIVIDER(16'd4), .CTRL_FLAGS(5'b00000), .POLL_MAX(4)) dut (
    .wb_clk_in(wb_clk_in), .wb_rst_in(wb_rst_in),
    .req_i(req_i), .req_dat_i(req_dat_i), .req_len_i(req_len_i),
    .done_o(done_o), .rx_dat_o(rx_dat_o), .err_o(err_o), .busy_o(busy_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  // ---------------- core model ----------------
  logic [31:0] c_div, c_ss, c_tx, c_ctrl, c_rx;
  int          gcnt;
  logic        stuck = 1'b0;

  function automatic logic [31:0] lmask(input logic [6:0] l);
    logic [31:0] one;
    one = 32'h1;
    if (l == 7'd0 || l >= 7'd32) return 32'hFFFF_FFFF;
    return (one << l) - 32'h1;
  endfunction

  always @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      m_ack_i <= 1'b0; m_dat_i <= '0;
      c_div <= '0; c_ss <= '0; c_tx <= '0; c_ctrl <= '0; c_rx <= '0; gcnt <= 0;
    end else begin
      m_ack_i <= m_cyc_o && m_stb_o && !m_ack_i;
      if (c_ctrl[8] && !stuck) begin
        if (gcnt == 0) begin
          c_ctrl[8] <= 1'b0;
          c_rx      <= c_tx & lmask(c_ctrl[6:0]);
        end else begin
          gcnt <= gcnt - 1;
        end
      end
      if (m_cyc_o && m_stb_o && !m_ack_i) begin
        if (m_we_o) begin
          if (!c_ctrl[8]) begin
            case (m_adr_o)
              5'h14: c_div <= m_dat_o;
              5'h18: c_ss  <= m_dat_o;
              5'h00: c_tx  <= m_dat_o;
              5'h10: begin c_ctrl <= m_dat_o; gcnt <= 3; end
              default: ;
            endcase
          end
        end else begin
          case (m_adr_o)
            5'h10:   m_dat_i <= c_ctrl;
            5'h00:   m_dat_i <= c_rx;
            5'h14:   m_dat_i <= c_div;
            5'h18:   m_dat_i <= c_ss;
            default: m_dat_i <= '0;
          endcase
        end
      end
    end
  end

  // ---------------- bus / done monitor ----------------
  int          cyc_cnt = 0, log_n = 0, grant_n = 0, acks_in = 0;
  int          v_stb = 0, v_gap = 0, v_ack = 0, v_done = 0;
  logic        prev_ack = 1'b0, prev_cyc = 1'b0, prev_done = 1'b0;
  logic [4:0]  log_adr [0:1023];
  logic        log_we  [0:1023];
  logic [31:0] log_dat [0:1023];
  int          g_idx [0:63];
  int          g_cyc [0:63];
  logic [31:0] g_rx  [0:63];
  logic        g_err [0:63];

  always @(posedge wb_clk_in) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wb_rst_in) begin
      prev_ack <= 1'b0; prev_cyc <= 1'b0; prev_done <= 1'b0; acks_in <= 0;
    end else begin
      if (m_stb_o && !m_cyc_o) v_stb <= v_stb + 1;
      if (prev_ack && m_stb_o) v_gap <= v_gap + 1;
      if (m_cyc_o && m_ack_i) acks_in <= acks_in + 1;
      if (prev_cyc && !m_cyc_o) begin
        if (acks_in != 1) v_ack <= v_ack + 1;
        acks_in <= 0;
      end
      if (m_cyc_o && m_stb_o && m_ack_i) begin
        log_adr[log_n] <= m_adr_o;
        log_we[log_n]  <= m_we_o;
        log_dat[log_n] <= m_we_o ? m_dat_o : m_dat_i;
        log_n <= log_n + 1;
      end
      if (done_o != 2'b00) begin
        if (done_o == 2'b11 || prev_done) v_done <= v_done + 1;
        g_idx[grant_n] <= done_o[1] ? 1 : 0;
        g_cyc[grant_n] <= cyc_cnt;
        g_rx[grant_n]  <= rx_dat_o;
        g_err[grant_n] <= err_o;
        grant_n <= grant_n + 1;
      end
      prev_ack  <= m_ack_i;
      prev_cyc  <= m_cyc_o;
      prev_done <= |done_o;
    end
  end

  task automatic wait_grants(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk_in);
      if (grant_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge wb_clk_in);
    n_chk++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b want 00", m_cyc_o, m_stb_o); end
    n_chk++; if (m_adr_o !== 5'h0 || m_dat_o !== 32'h0 || m_sel_o !== 4'h0 || m_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_bus: adr %h dat %h sel %h we %b want all 0", m_adr_o, m_dat_o, m_sel_o, m_we_o); end
    n_chk++; if (done_o !== 2'b00 || err_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_status: done %b err %b busy %b want 0", done_o, err_o, busy_o); end
    n_chk++; if (rx_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_rx: got %h want 0", rx_dat_o); end
    wb_rst_in = 1'b0;
    repeat (2) @(negedge wb_clk_in);
    $display("test_reset done");
  endtask

  task automatic test_single();
    int base_l, base_g, t0, npoll, nl;
    bit ok;
    base_l = log_n; base_g = grant_n;
    @(negedge wb_clk_in);
    req_dat_i[31:0] = 32'h0000_00A5; req_len_i[6:0] = 7'd8; req_i[0] = 1'b1;
    t0 = cyc_cnt;
    @(negedge wb_clk_in);
    n_chk++; if (busy_o !== 1'b1 || m_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_grant: busy %b stb %b want 1 0", busy_o, m_stb_o); end
    @(negedge wb_clk_in);
    n_chk++; if (m_stb_o !== 1'b1 || m_cyc_o !== 1'b1 || m_adr_o !== 5'h14 || m_sel_o !== 4'hF) begin n_fail++; $display("FAIL single_first_stb: stb %b cyc %b adr %h sel %h want 1 1 14 f", m_stb_o, m_cyc_o, m_adr_o, m_sel_o); end
    wait_grants(base_g + 1, 200, ok);
    req_i[0] = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no done within 200 cycles, got %0d want %0d", grant_n, base_g + 1); end
    n_chk++; if (g_idx[base_g] != 0 || g_rx[base_g] !== 32'h0000_00A5 || g_err[base_g] !== 1'b0) begin n_fail++; $display("FAIL single_result: idx %0d rx %h err %b want 0 000000a5 0", g_idx[base_g], g_rx[base_g], g_err[base_g]); end
    n_chk++; if (log_adr[base_l] !== 5'h14 || log_we[base_l] !== 1'b1 || log_dat[base_l] !== 32'h4) begin n_fail++; $display("FAIL single_wr_div: adr %h we %b dat %h want 14 1 4", log_adr[base_l], log_we[base_l], log_dat[base_l]); end
    n_chk++; if (log_adr[base_l+1] !== 5'h18 || log_dat[base_l+1] !== 32'h1) begin n_fail++; $display("FAIL single_wr_ss: adr %h dat %h want 18 1", log_adr[base_l+1], log_dat[base_l+1]); end
    n_chk++; if (log_adr[base_l+2] !== 5'h00 || log_we[base_l+2] !== 1'b1 || log_dat[base_l+2] !== 32'hA5) begin n_fail++; $display("FAIL single_wr_tx: adr %h we %b dat %h want 00 1 a5", log_adr[base_l+2], log_we[base_l+2], log_dat[base_l+2]); end
    n_chk++; if (log_adr[base_l+3] !== 5'h10 || log_dat[base_l+3] !== 32'h108) begin n_fail++; $display("FAIL single_wr_ctrl: adr %h dat %h want 10 108", log_adr[base_l+3], log_dat[base_l+3]); end
    npoll = 0;
    nl = log_n;
    for (int i = base_l + 4; i < nl; i++) if (log_adr[i] == 5'h10 && !log_we[i]) npoll++;
    n_chk++; if (npoll != 2 || nl - base_l != 7) begin n_fail++; $display("FAIL single_polls: polls %0d accesses %0d want 2 7", npoll, nl - base_l); end
    n_chk++; if (log_adr[nl-1] !== 5'h00 || log_we[nl-1] !== 1'b0 || log_dat[nl-1] !== 32'hA5) begin n_fail++; $display("FAIL single_rd_rx: adr %h we %b dat %h want 00 0 a5", log_adr[nl-1], log_we[nl-1], log_dat[nl-1]); end
    n_chk++; if (g_cyc[base_g] - t0 != 17 + 3 * 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", g_cyc[base_g] - t0, 23); end
    n_chk++; if (done_o !== 2'b00 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_after_done: done %b busy %b want 00 0", done_o, busy_o); end
    repeat (3) @(negedge wb_clk_in);
    $display("test_single done");
  endtask

  task automatic test_both();
    int base_l, base_g, k;
    bit ok;
    logic [31:0] exp_ss [0:3];
    exp_ss[0] = 32'h1; exp_ss[1] = 32'h2; exp_ss[2] = 32'h1; exp_ss[3] = 32'h2;
    @(negedge wb_clk_in); wb_rst_in = 1'b1;
    repeat (2) @(negedge wb_clk_in); wb_rst_in = 1'b0;
    base_l = log_n; base_g = grant_n;
    req_dat_i = {32'h22, 32'h11}; req_len_i = {7'd8, 7'd8}; req_i = 2'b11;
    wait_grants(base_g + 4, 600, ok);
    req_i = 2'b00;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL both_timeout: got %0d grants want 4", grant_n - base_g); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (g_idx[base_g+i] != (i % 2) || g_rx[base_g+i] !== ((i % 2) ? 32'h22 : 32'h11)) begin n_fail++; $display("FAIL both_grant%0d: idx %0d rx %h want %0d %h", i, g_idx[base_g+i], g_rx[base_g+i], i % 2, (i % 2) ? 32'h22 : 32'h11); end
    end
    k = 0;
    for (int i = base_l; i < log_n; i++) begin
      if (log_adr[i] == 5'h18 && log_we[i] && k < 4) begin
        n_chk++; if (log_dat[i] !== exp_ss[k]) begin n_fail++; $display("FAIL both_ss%0d: got %h want %h", k, log_dat[i], exp_ss[k]); end
        k++;
      end
    end
    repeat (3) @(negedge wb_clk_in);
    $display("test_both done");
  endtask

  task automatic test_back_to_back();
    int base_g, seen;
    bit ok;
    base_g = grant_n; seen = grant_n; ok = 1'b0;
    @(negedge wb_clk_in);
    req_dat_i = {32'h33, 32'h44}; req_len_i = {7'd8, 7'd8}; req_i[1] = 1'b1;
    repeat (2) @(negedge wb_clk_in);
    req_i[0] = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge wb_clk_in);
      if (grant_n > seen) begin
        if (g_idx[grant_n-1] == 0) req_i[0] = 1'b0;
        seen = grant_n;
      end
      if (grant_n >= base_g + 4) begin ok = 1'b1; break; end
    end
    req_i = 2'b00;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d grants want 4", grant_n - base_g); end
    n_chk++; if (g_idx[base_g] != 1 || g_idx[base_g+1] != 0 || g_idx[base_g+2] != 1 || g_idx[base_g+3] != 1) begin n_fail++; $display("FAIL rr_order: got %0d%0d%0d%0d want 1011", g_idx[base_g], g_idx[base_g+1], g_idx[base_g+2], g_idx[base_g+3]); end
    n_chk++; if (g_rx[base_g+1] !== 32'h44 || g_rx[base_g+3] !== 32'h33) begin n_fail++; $display("FAIL rr_data: got %h %h want 44 33", g_rx[base_g+1], g_rx[base_g+3]); end
    repeat (3) @(negedge wb_clk_in);
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    int base_l, base_g, nctrl, nrx;
    bit ok;
    base_l = log_n; base_g = grant_n;
    @(negedge wb_clk_in);
    stuck = 1'b1;
    req_dat_i[31:0] = 32'hDEAD_BEEF; req_len_i[6:0] = 7'd0; req_i[0] = 1'b1;
    wait_grants(base_g + 1, 300, ok);
    req_i[0] = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_nodone: got %0d want %0d", grant_n, base_g + 1); end
    n_chk++; if (g_err[base_g] !== 1'b1 || g_rx[base_g] !== 32'h0 || g_idx[base_g] != 0) begin n_fail++; $display("FAIL tmo_result: err %b rx %h idx %0d want 1 0 0", g_err[base_g], g_rx[base_g], g_idx[base_g]); end
    nctrl = 0; nrx = 0;
    for (int i = base_l; i < log_n; i++) begin
      if (log_adr[i] == 5'h10 && !log_we[i]) nctrl++;
      if (log_adr[i] == 5'h00 && !log_we[i]) nrx++;
    end
    n_chk++; if (nctrl != 4 || nrx != 0) begin n_fail++; $display("FAIL tmo_polls: ctrl reads %0d rx reads %0d want 4 0", nctrl, nrx); end
    n_chk++; if (log_dat[base_l+3] !== 32'h100) begin n_fail++; $display("FAIL tmo_ctrl_word: got %h want 100", log_dat[base_l+3]); end
    repeat (3) @(negedge wb_clk_in);
    $display("test_timeout done");
  endtask

  task automatic test_reset_poll();
    int base_l, base_g;
    bit ok, seen;
    seen = 1'b0;
    @(negedge wb_clk_in);
    req_dat_i[31:0] = 32'h5A; req_len_i[6:0] = 7'd8; req_i[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_in);
      if (m_stb_o && m_adr_o == 5'h10 && !m_we_o) begin seen = 1'b1; break; end
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rstpoll_nopoll: no CTRL read within 100 cycles, got 0 want 1"); end
    #2 wb_rst_in = 1'b1;
    #1;
    n_chk++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin n_fail++; $display("FAIL rstpoll_async: cyc %b stb %b want 0 0", m_cyc_o, m_stb_o); end
    n_chk++; if (busy_o !== 1'b0 || m_adr_o !== 5'h0 || m_dat_o !== 32'h0 || rx_dat_o !== 32'h0) begin n_fail++; $display("FAIL rstpoll_outputs: busy %b adr %h dat %h rx %h want 0", busy_o, m_adr_o, m_dat_o, rx_dat_o); end
    @(negedge wb_clk_in);
    stuck = 1'b0;
    base_l = log_n; base_g = grant_n;
    wb_rst_in = 1'b0;
    wait_grants(base_g + 1, 200, ok);
    req_i[0] = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rstpoll_nodone: got %0d want %0d", grant_n, base_g + 1); end
    n_chk++; if (log_adr[base_l] !== 5'h14 || log_we[base_l] !== 1'b1) begin n_fail++; $display("FAIL rstpoll_restart: adr %h we %b want 14 1", log_adr[base_l], log_we[base_l]); end
    n_chk++; if (g_rx[base_g] !== 32'h5A || g_err[base_g] !== 1'b0) begin n_fail++; $display("FAIL rstpoll_result: rx %h err %b want 5a 0", g_rx[base_g], g_err[base_g]); end
    repeat (3) @(negedge wb_clk_in);
    $display("test_reset_poll done");
  endtask

  task automatic test_protocol();
    n_chk++; if (v_stb + v_gap + v_ack + v_done != 0) begin n_fail++; $display("FAIL protocol: stb_no_cyc %0d no_gap %0d ack_count %0d done_shape %0d want 0", v_stb, v_gap, v_ack, v_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_timeout();
    test_reset_poll();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
